// File: rtl/fire5_squeeze_ofm_writer_pkg.sv
// fire_pkg: shared types and sizing helpers for the fire5 squeeze OFM writer.
// Holds the writer state encoding, default layer geometry and width helpers.
package fire_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRAIN = 2'd1,
        ST_DONE  = 2'd2
    } wr_state_e;

    localparam int WOUT_DEFAULT = 32;
    localparam int PIX_TOTAL    = WOUT_DEFAULT * WOUT_DEFAULT;
    localparam int CH_STRIDE    = WOUT_DEFAULT * WOUT_DEFAULT;

    // Smallest address width that reaches the last word of the layer.
    function automatic int fire_addr_w(input int base,
                                       input int dsp,
                                       input int wout);
        int top;
        top = base + dsp * wout * wout;
        return (top > 1) ? $clog2(top) : 1;
    endfunction

    // Counter width able to index 0..n-1 (at least one bit).
    function automatic int fire_cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fire5_squeeze_ofm_writer_if.sv
// Bundle between the fire5 squeeze producer and the OFM writer / RAM port.
// master: producer side (drives sample/vector); slave: the writer.
interface fire5_squeeze_ofm_writer_if #(
    parameter int WIDTH  = 16,
    parameter int DSP_NO = 32,
    parameter int ADDR_W = 15
);

    logic              writer_en;
    logic              fire5_squeeze_sample;
    logic [WIDTH-1:0]  ofm_in [0:DSP_NO-1];
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [WIDTH-1:0]  ram_wdata;
    logic              ram_feedback;
    logic              writer_done;
    logic              overflow_err;

    modport master (
        output writer_en,
        output fire5_squeeze_sample,
        output ofm_in,
        input  ram_we,
        input  ram_addr,
        input  ram_wdata,
        input  ram_feedback,
        input  writer_done,
        input  overflow_err
    );

    modport slave (
        input  writer_en,
        input  fire5_squeeze_sample,
        input  ofm_in,
        output ram_we,
        output ram_addr,
        output ram_wdata,
        output ram_feedback,
        output writer_done,
        output overflow_err
    );

endinterface

// File: rtl/fire5_squeeze_ofm_writer_addr_gen.sv
// fire_addr_gen: channel/pixel counters and running RAM address for the drain.
// Ports: clk, rst (sync, active low), i_step (a write issues this cycle),
// o_ch / o_addr (word being written), o_last_ch / o_last_pix flags.
module fire_addr_gen
    import fire_pkg::*;
#(
    parameter int DSP_NO    = 32,
    parameter int WOUT      = 32,
    parameter int BASE_ADDR = 0,
    parameter int ADDR_W    = 15,
    parameter int CH_W      = fire_cnt_w(DSP_NO)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_step,
    output logic [CH_W-1:0]   o_ch,
    output logic [ADDR_W-1:0] o_addr,
    output logic              o_last_ch,
    output logic              o_last_pix
);

    localparam int PIX   = WOUT * WOUT;
    localparam int PIX_W = fire_cnt_w(PIX + 1);

    localparam logic [ADDR_W-1:0] BASE     = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] STRIDE   = ADDR_W'(PIX);
    localparam logic [ADDR_W-1:0] ONE_A    = ADDR_W'(1);
    localparam logic [CH_W-1:0]   CH_LAST  = CH_W'(DSP_NO - 1);
    localparam logic [CH_W-1:0]   ONE_C    = CH_W'(1);
    localparam logic [PIX_W-1:0]  PIX_LAST = PIX_W'(PIX - 1);
    localparam logic [PIX_W-1:0]  ONE_P    = PIX_W'(1);

    logic [CH_W-1:0]   r_ch_cnt;
    logic [PIX_W-1:0]  r_pix_cnt;
    logic [ADDR_W-1:0] r_pix_base;
    logic [ADDR_W-1:0] r_addr;

    assign o_ch       = r_ch_cnt;
    assign o_addr     = r_addr;
    assign o_last_ch  = (r_ch_cnt == CH_LAST);
    assign o_last_pix = (r_pix_cnt == PIX_LAST);

    // r_addr always points at the word for r_ch_cnt, so an accepted sample
    // needs no setup: the counters are already at channel 0 of the pixel.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_ch_cnt   <= '0;
            r_pix_cnt  <= '0;
            r_pix_base <= BASE;
            r_addr     <= BASE;
        end else if (i_step) begin
            if (o_last_ch) begin
                r_ch_cnt   <= '0;
                r_pix_cnt  <= r_pix_cnt + ONE_P;
                r_pix_base <= r_pix_base + ONE_A;
                r_addr     <= r_pix_base + ONE_A;
            end else begin
                r_ch_cnt <= r_ch_cnt + ONE_C;
                r_addr   <= r_addr + STRIDE;
            end
        end
    end

endmodule

// File: rtl/fire5_squeeze_ofm_writer.sv
// fire5_squeeze_ofm_writer: captures the squeeze OFM vector and serialises it
// channel-major into a single-port RAM, one word per cycle.
// Ports: clk, rst (sync, active low), bus (fire5_squeeze_ofm_writer_if.slave:
// writer_en, sample, ofm_in in; ram_we/addr/wdata, ram_feedback,
// writer_done, overflow_err out).
// FIRE_OFM_ZERO_COUNT_EN adds o_nonzero_cnt, a count of nonzero words written.
module fire5_squeeze_ofm_writer
    import fire_pkg::*;
#(
    parameter int WIDTH     = 16,
    parameter int DSP_NO    = 32,
    parameter int WOUT      = 32,
    parameter int BASE_ADDR = 0,
    parameter int ADDR_W    = fire_addr_w(BASE_ADDR, DSP_NO, WOUT)
) (
    input logic clk,
    input logic rst,
    fire5_squeeze_ofm_writer_if.slave bus
`ifdef FIRE_OFM_ZERO_COUNT_EN
    ,
    output logic [$clog2(DSP_NO*WOUT*WOUT):0] o_nonzero_cnt
`endif
);

    localparam int CH_W = fire_cnt_w(DSP_NO);

    wr_state_e r_state;
    wr_state_e w_state_nxt;

    logic [WIDTH-1:0]  r_buf [0:DSP_NO-1];

    logic [CH_W-1:0]   w_ch;
    logic [ADDR_W-1:0] w_addr;
    logic              w_last_ch;
    logic              w_last_pix;

    logic              w_busy;
    logic              w_sample;
    logic              w_accept;
    logic              w_drop;

    logic              w_we;
    logic              w_fb_nxt;
    logic              w_done_nxt;

    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [WIDTH-1:0]  r_wdata;
    logic              r_fb;
    logic              r_done;
    logic              r_ovf;

    assign w_busy   = (r_state == ST_DRAIN);
    assign w_sample = bus.fire5_squeeze_sample & bus.writer_en;

    // A sample on the final write of the final pixel is not taken: the
    // layer is complete and the writer heads to DONE.
    assign w_accept = w_sample && (r_state != ST_DONE) &&
                      (!w_busy || (w_last_ch && !w_last_pix));
    assign w_drop   = w_sample && w_busy && !w_last_ch;

    fire_addr_gen #(
        .DSP_NO    (DSP_NO),
        .WOUT      (WOUT),
        .BASE_ADDR (BASE_ADDR),
        .ADDR_W    (ADDR_W),
        .CH_W      (CH_W)
    ) u_addr_gen (
        .clk        (clk),
        .rst        (rst),
        .i_step     (w_busy),
        .o_ch       (w_ch),
        .o_addr     (w_addr),
        .o_last_ch  (w_last_ch),
        .o_last_pix (w_last_pix)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (w_last_ch) begin
                    if (w_last_pix) begin
                        w_state_nxt = ST_DONE;
                    end else if (!w_accept) begin
                        w_state_nxt = ST_IDLE;
                    end
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_DONE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Every DRAIN cycle issues one word; feedback mirrors the write window.
    always_comb begin
        w_we       = w_busy;
        w_fb_nxt   = w_busy;
        w_done_nxt = (r_state == ST_DONE);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_fb    <= 1'b0;
            r_done  <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            r_we   <= w_we;
            r_fb   <= w_fb_nxt;
            r_done <= w_done_nxt;
            if (w_drop) begin
                r_ovf <= 1'b1;
            end
            if (w_we) begin
                r_addr  <= w_addr;
                r_wdata <= r_buf[w_ch];
            end
        end
    end

    // Contents are don't-care out of reset, so the buffer has no reset.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_buf <= bus.ofm_in;
        end
    end

    assign bus.ram_we       = r_we;
    assign bus.ram_addr     = r_addr;
    assign bus.ram_wdata    = r_wdata;
    assign bus.ram_feedback = r_fb;
    assign bus.writer_done  = r_done;
    assign bus.overflow_err = r_ovf;

`ifdef FIRE_OFM_ZERO_COUNT_EN
    localparam int NZ_W = $clog2(DSP_NO * WOUT * WOUT) + 1;
    localparam logic [NZ_W-1:0] ONE_NZ = NZ_W'(1);

    logic [NZ_W-1:0] r_nz_cnt;

    // Counted at issue time; only DRAIN issues words, so DONE freezes it.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_nz_cnt <= '0;
        end else if (w_we && (r_buf[w_ch] != '0)) begin
            r_nz_cnt <= r_nz_cnt + ONE_NZ;
        end
    end

    assign o_nonzero_cnt = r_nz_cnt;
`endif

endmodule

// File: tb/tb_fire5_squeeze_ofm_writer.sv
// Bench for fire5_squeeze_ofm_writer: random vectors and sample timing checked
// every cycle against a transaction-level model of the expected RAM writes.
module tb_fire5_squeeze_ofm_writer;

    localparam int WIDTH     = 16;
    localparam int DSP_NO    = 32;
    localparam int WOUT      = 32;
    localparam int BASE_ADDR = 0;
    localparam int ADDR_W    = 15;
    localparam int PIX       = WOUT * WOUT;
    localparam int NEVER     = 32'h7fff_ffff;

    typedef struct {
        int cyc;
        int addr;
        int data;
    } wr_t;

    logic clk = 1'b0;
    logic rst = 1'b0;

    always #5 clk = ~clk;

    fire5_squeeze_ofm_writer_if #(
        .WIDTH  (WIDTH),
        .DSP_NO (DSP_NO),
        .ADDR_W (ADDR_W)
    ) bus ();

`ifdef FIRE_OFM_ZERO_COUNT_EN
    logic [$clog2(DSP_NO*PIX):0] nz_cnt;
`endif

    fire5_squeeze_ofm_writer #(
        .WIDTH     (WIDTH),
        .DSP_NO    (DSP_NO),
        .WOUT      (WOUT),
        .BASE_ADDR (BASE_ADDR),
        .ADDR_W    (ADDR_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
`ifdef FIRE_OFM_ZERO_COUNT_EN
        ,
        .o_nonzero_cnt (nz_cnt)
`endif
    );

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;

    // Reference model: the list of RAM writes the layer must produce.
    wr_t q[$];
    int  m_acc      = 0;
    int  m_busy_end = -1;
    int  m_ovf_cyc  = NEVER;
    int  m_done_cyc = NEVER;
    int  last_a     = 0;
    int  last_d     = 0;
    int  m_nz       = 0;
    int  pat_mode   = 0;
    int  guard      = 0;

    logic [WIDTH-1:0] cur [0:DSP_NO-1];

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
        end
    endtask

    // Sample presented for edge s: one pixel = DSP_NO writes, one per cycle,
    // starting the cycle after; a busy writer only takes it on its last write.
    task automatic model_edge(input int s, input bit rst_v, input bit smp);
        if (!rst_v) begin
            q.delete();
            m_acc      = 0;
            m_busy_end = -1;
            m_ovf_cyc  = NEVER;
            m_done_cyc = NEVER;
            last_a     = 0;
            last_d     = 0;
            m_nz       = 0;
        end else if (smp) begin
            if (s < m_busy_end) begin
                if (m_ovf_cyc == NEVER) m_ovf_cyc = s;
            end else if (m_acc < PIX) begin
                for (int c = 0; c < DSP_NO; c++) begin
                    q.push_back('{s + 1 + c,
                                  BASE_ADDR + c * PIX + m_acc,
                                  int'(cur[c])});
                end
                m_busy_end = s + DSP_NO;
                m_acc++;
                if (m_acc == PIX) m_done_cyc = s + DSP_NO + 1;
            end
        end
    endtask

    task automatic check_cycle(input int k);
        bit ew;
        ew = (q.size() > 0) && (q[0].cyc == k);
        if (ew) begin
            last_a = q[0].addr;
            last_d = q[0].data;
            if (q[0].data != 0) m_nz++;
            void'(q.pop_front());
        end
        chk("ram_we", 32'(bus.ram_we), 32'(ew));
        chk("ram_addr", 32'(bus.ram_addr), last_a);
        chk("ram_wdata", 32'(bus.ram_wdata), last_d);
        chk("ram_feedback", 32'(bus.ram_feedback), 32'(ew));
        chk("writer_done", 32'(bus.writer_done), 32'(k >= m_done_cyc));
        chk("overflow_err", 32'(bus.overflow_err), 32'(k >= m_ovf_cyc));
`ifdef FIRE_OFM_ZERO_COUNT_EN
        chk("nonzero_cnt", 32'(nz_cnt), m_nz);
`endif
    endtask

    task automatic step(input bit rst_v, input bit smp, input bit en);
        for (int c = 0; c < DSP_NO; c++) begin
            if (pat_mode == 1) cur[c] = WIDTH'(c + 1);
            else if ($urandom_range(0, 7) == 0) cur[c] = '0;
            else cur[c] = WIDTH'($urandom);
            bus.ofm_in[c] = cur[c];
        end
        rst = rst_v;
        bus.fire5_squeeze_sample = smp;
        bus.writer_en = en;
        model_edge(cyc + 1, rst_v, smp && en);
        @(posedge clk);
        cyc++;
        @(negedge clk);
        check_cycle(cyc);
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b1, 1'b0, 1'b1);
    endtask

    initial begin
        // reset held with the sample pulsing
        repeat (3) step(1'b0, 1'b1, 1'b1);
        idle(2);

        // single sample, data c+1
        pat_mode = 1;
        step(1'b1, 1'b1, 1'b1);
        pat_mode = 0;
        idle(40);

        // back-to-back on the last drain write
        step(1'b1, 1'b1, 1'b1);
        idle(31);
        step(1'b1, 1'b1, 1'b1);
        idle(70);

        // overflow at ch_cnt==10
        step(1'b1, 1'b1, 1'b1);
        idle(10);
        step(1'b1, 1'b1, 1'b1);
        idle(40);

        // writer_en low
        step(1'b1, 1'b1, 1'b0);
        idle(3);

        // reset mid-drain at ch_cnt==5, then a fresh sample
        step(1'b1, 1'b1, 1'b1);
        idle(5);
        step(1'b0, 1'b0, 1'b1);
        idle(2);
        step(1'b1, 1'b1, 1'b1);
        idle(40);

        // full layer from a clean reset, never overrunning the writer
        step(1'b0, 1'b0, 1'b1);
        idle(2);
        guard = 0;
        while (cyc < m_done_cyc && guard < 60000) begin
            bit smp;
            smp = (cyc + 1 >= m_busy_end) && ($urandom_range(0, 2) != 0);
            step(1'b1, smp, $urandom_range(0, 9) != 0);
            guard++;
        end
        if (guard >= 60000) chk("completion_timeout", 32'(bus.writer_done), 32'd1);
        idle(4);

        // sample after completion: no write, no overflow
        step(1'b1, 1'b1, 1'b1);
        idle(40);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
